cla_slice_seq_ctrl: RTL

//  Multi-cycle sequencer that performs a WIDTH-bit addition by time-sharing a

---
 rtl/cla_slice_seq_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/cla_slice_seq_ctrl.sv
// Nibble-serial WIDTH-bit adder sequencer driving one external 4-bit CLA slice.
// Optional signed-overflow output is built only when OVERFLOW_FLAG_EN is defined.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for operands, in_ready=1, slice inputs held at 0
// RUN    | one nibble per cycle through the slice, LSB first
// DONE   | result held with out_valid=1 until the consumer takes it
module cla_slice_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [3:0]       slice_a,
    output logic [3:0]       slice_b,
    output logic             slice_cin,
    input  logic [3:0]       slice_sum,
    input  logic             slice_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef OVERFLOW_FLAG_EN
    ,
    output logic             ovf
`endif
);

    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q;
    logic [WIDTH-1:0] op_a_q, op_b_q;
    logic             carry_q;
    logic             accept;
    logic             last_nib;
    logic             release_res;

    assign last_nib = (idx_q == IW'(NIB - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        accept      = 1'b0;
        release_res = 1'b0;
        slice_a     = 4'h0;
        slice_b     = 4'h0;
        slice_cin   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                slice_a   = op_a_q[{idx_q, 2'b00} +: 4];
                slice_b   = op_b_q[{idx_q, 2'b00} +: 4];
                slice_cin = carry_q;
                if (last_nib) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    release_res = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The slice result lands directly in the output register, one nibble per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            carry_q <= 1'b0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end else if (accept) begin
            op_a_q  <= a;
            op_b_q  <= b;
            carry_q <= cin;
            idx_q   <= '0;
        end else if (state_q == S_RUN) begin
            sum[{idx_q, 2'b00} +: 4] <= slice_sum;
            carry_q                  <= slice_cout;
            idx_q                    <= idx_q + 1'b1;
            if (last_nib) begin
                cout <= slice_cout;
            end
        end
    end

`ifdef OVERFLOW_FLAG_EN
    // Overflow is judged on the final slice's sum MSB, so it settles with cout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (release_res) begin
            ovf <= 1'b0;
        end else if ((state_q == S_RUN) && last_nib) begin
            ovf <= (op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) &&
                   (slice_sum[3] != op_a_q[WIDTH-1]);
        end
    end
`endif

endmodule
